// File: rtl/seq_residual_pingpong.sv
// seq_residual_pingpong
// Two-bank sequence buffer for the encoder pipeline. One bank captures
// SEQ_LEN tokens from the upstream sublayer, optionally adding a residual
// operand to each one. The other bank replays a completed sequence, in order,
// through a registered valid/ready output.
module seq_residual_pingpong #(
   parameter int DATA_W   = 16,
   parameter int SEQ_LEN  = 30,
   parameter int ADDR_W   = $clog2(SEQ_LEN),
   parameter int RESIDUAL = 1,
   parameter int SATURATE = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     wr_valid,
   output logic                     wr_ready,
   input  logic signed [DATA_W-1:0] wr_data,
   input  logic signed [DATA_W-1:0] wr_skip,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [DATA_W-1:0] out_data,
   output logic        [ADDR_W-1:0] out_idx,
   output logic                     out_last,
   output logic                     seq_done,
   output logic                     err_overflow,
   output logic [1:0]               banks_full
);

   // Both banks live in one array: bank 0 at [0, SEQ_LEN), bank 1 at
   // [SEQ_LEN, 2*SEQ_LEN). One extra address bit covers both.
   localparam int                DEPTH    = 2 * SEQ_LEN;
   localparam int                MEM_AW   = ADDR_W + 1;
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(SEQ_LEN - 1);

   // Clamp value for a sum that left the signed DATA_W range.
   function automatic logic signed [DATA_W-1:0] sat_clamp(input logic neg);
      return neg ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
   endfunction

   // Residual add at DATA_W+1 bits. It saturates or wraps according to
   // SATURATE. Overflow shows up as a disagreement between the two top bits.
   function automatic logic signed [DATA_W-1:0] res_add(
      input logic signed [DATA_W-1:0] a,
      input logic signed [DATA_W-1:0] b
   );
      logic signed [DATA_W:0] sum;
      sum = (DATA_W+1)'(a) + (DATA_W+1)'(b);
      if ((SATURATE != 0) && (sum[DATA_W] != sum[DATA_W-1]))
         return sat_clamp(sum[DATA_W]);
      return sum[DATA_W-1:0];
   endfunction

   // Flat memory address of (bank, index).
   function automatic logic [MEM_AW-1:0] bank_addr(
      input logic              bank,
      input logic [ADDR_W-1:0] idx
   );
      return bank ? (MEM_AW'(SEQ_LEN) + {1'b0, idx}) : {1'b0, idx};
   endfunction

   logic signed [DATA_W-1:0] mem [DEPTH];

   // Write-side state.
   logic              wr_bank;
   logic [ADDR_W-1:0] wr_idx;
   logic [1:0]        banks_full_r;
   logic              err_r;

   // Fetch pointer: the next token to move from memory into the output register.
   logic              fetch_bank;
   logic [ADDR_W-1:0] fetch_idx;

   // Output register stage.
   logic                     vld_p1;
   logic signed [DATA_W-1:0] data_p1;
   logic        [ADDR_W-1:0] idx_p1;
   logic                     last_p1;
   logic                     done_p1;

   // Combinational write / fetch decisions.
   logic signed [DATA_W-1:0] wr_sum_p0;
   logic [MEM_AW-1:0]        wr_addr_p0;
   logic [MEM_AW-1:0]        rd_addr_p0;
   logic                     wr_acc;
   logic                     wr_wrap;
   logic                     rd_acc;
   logic                     rd_done;
   logic                     pend_last;
   logic [1:0]               avail;
   logic                     load_p0;

   assign wr_ready = (banks_full_r != 2'd2);

   // Write-side value and handshake decisions for this cycle.
   always_comb begin
      wr_sum_p0  = (RESIDUAL != 0) ? res_add(wr_data, wr_skip) : wr_data;
      wr_addr_p0 = bank_addr(wr_bank, wr_idx);
      wr_acc     = wr_valid && wr_ready && !flush;
      wr_wrap    = wr_acc && (wr_idx == LAST_IDX);
   end

   // Read-side decisions. When the output register holds the last token of a
   // bank, that bank has been fetched completely but still counts in
   // banks_full. It is therefore excluded from what may still be fetched,
   // which keeps the next bank from being fetched before it is full.
   always_comb begin
      rd_acc     = vld_p1 && out_ready;
      rd_done    = rd_acc && last_p1;
      pend_last  = vld_p1 && last_p1;
      avail      = banks_full_r - {1'b0, pend_last};
      load_p0    = (avail != 2'd0) && (!vld_p1 || out_ready);
      rd_addr_p0 = bank_addr(fetch_bank, fetch_idx);
   end

   // Token storage; an accepted write lands in the current write bank.
   always_ff @(posedge clk) begin
      if (wr_acc)
         mem[wr_addr_p0] <= wr_sum_p0;
   end

   // Control and output register: pointers, bank count, replay, error flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_bank      <= 1'b0;
         wr_idx       <= '0;
         banks_full_r <= 2'd0;
         err_r        <= 1'b0;
         fetch_bank   <= 1'b0;
         fetch_idx    <= '0;
         vld_p1       <= 1'b0;
         data_p1      <= '0;
         idx_p1       <= '0;
         last_p1      <= 1'b0;
         done_p1      <= 1'b0;
      end else begin
         // A dropped write is sticky. Only rst clears it.
         if (wr_valid && !wr_ready)
            err_r <= 1'b1;

         if (flush) begin
            wr_bank      <= 1'b0;
            wr_idx       <= '0;
            banks_full_r <= 2'd0;
            fetch_bank   <= 1'b0;
            fetch_idx    <= '0;
            vld_p1       <= 1'b0;
            data_p1      <= '0;
            idx_p1       <= '0;
            last_p1      <= 1'b0;
            done_p1      <= 1'b0;
         end else begin
            // ---- write pointer ----
            if (wr_acc) begin
               wr_idx <= wr_wrap ? '0 : (wr_idx + ADDR_W'(1));
               if (wr_wrap)
                  wr_bank <= ~wr_bank;
            end

            // A bank completing on both sides in one cycle cancels out.
            banks_full_r <= banks_full_r + {1'b0, wr_wrap} - {1'b0, rd_done};

            // ---- stage p0 -> p1: memory read into the output register ----
            if (load_p0) begin
               data_p1 <= mem[rd_addr_p0];
               idx_p1  <= fetch_idx;
               last_p1 <= (fetch_idx == LAST_IDX);
               vld_p1  <= 1'b1;
               if (fetch_idx == LAST_IDX) begin
                  fetch_idx  <= '0;
                  fetch_bank <= ~fetch_bank;
               end else begin
                  fetch_idx <= fetch_idx + ADDR_W'(1);
               end
            end else if (rd_acc) begin
               vld_p1 <= 1'b0;
            end

            done_p1 <= rd_done;
         end
      end
   end

   assign out_valid    = vld_p1;
   assign out_data     = data_p1;
   assign out_idx      = idx_p1;
   assign out_last     = last_p1;
   assign seq_done     = done_p1;
   assign err_overflow = err_r;
   assign banks_full   = banks_full_r;

endmodule
